error_inject_frame: RTL and testbench

- Clocked, parametrised successor to the team's strobe-driven serial error injector.
- Accepts a serial codeword stream, one bit per accepted beat, in frames of FRAME_LEN bits, MSB position first.
- Flips selected bit positions according to a per-frame latched mode: pass, fixed position, mask, or triggered one-shot.
- Sits between the encoder's serialiser and the decoder in the ECC lab datapath; valid/ready handshakes on both sides; frame and error counters for the bench.

---
 rtl/error_inject_frame.sv | 166 ++++++++++++++++
 tb/tb_error_inject_frame.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/error_inject_frame.sv
// Serial frame error injector between serialiser and decoder.
// Flips chosen bit positions per a mode latched at each frame start.
module error_inject_frame #(
  parameter int FRAME_LEN = 7,
  parameter int POS_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sof_in,
  input  logic [1:0]           mode,
  input  logic [POS_W-1:0]     err_pos,
  input  logic [FRAME_LEN-1:0] err_mask,
  input  logic                 inj_trigger,
  output logic                 d_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sof_out,
  output logic                 eof_out,
  output logic                 flipped,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_FIX  = 2'b01;
  localparam logic [1:0] M_MASK = 2'b10;
  localparam logic [1:0] M_SHOT = 2'b11;

  localparam logic [POS_W-1:0] P_FIRST = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] P_LAST  = '0;

  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 armed_q, armed_d;
  logic [1:0]           mode_q, mode_d;
  logic [POS_W-1:0]     epos_q, epos_d;
  logic [FRAME_LEN-1:0] mask_q, mask_d;
  logic                 shot_q, shot_d;
  logic                 dout_q, dout_d;
  logic                 ov_q, ov_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 flip_q, flip_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]     ecnt_q, ecnt_d;

  logic                 accept;
  logic [POS_W-1:0]     p;
  logic                 start;
  logic                 arm_hit;
  logic [1:0]           cur_mode;
  logic [POS_W-1:0]     cur_pos;
  logic [FRAME_LEN-1:0] cur_mask;
  logic                 cur_shot;
  logic                 flip;

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;

  // sof_in realigns the accepted bit to the first position
  assign p       = sof_in ? P_FIRST : pos_q;
  assign start   = accept && (p == P_FIRST);
  assign arm_hit = (mode == M_SHOT) && (armed_q || inj_trigger);

  // first bit of a frame sees live config, later bits the latched copy
  assign cur_mode = start ? mode     : mode_q;
  assign cur_pos  = start ? err_pos  : epos_q;
  assign cur_mask = start ? err_mask : mask_q;
  assign cur_shot = start ? arm_hit  : shot_q;

  // flip decision for the bit at position p
  always_comb begin
    flip = 1'b0;
    unique case (cur_mode)
      M_PASS: flip = 1'b0;
      M_FIX:  flip = (p == cur_pos);
      M_MASK: flip = cur_mask[p];
      M_SHOT: flip = cur_shot && (p == cur_pos);
      default: flip = 1'b0;
    endcase
  end

  // next-state: position, config latch, output register, counters
  always_comb begin
    pos_d   = pos_q;
    mode_d  = mode_q;
    epos_d  = epos_q;
    mask_d  = mask_q;
    shot_d  = shot_q;
    dout_d  = dout_q;
    ov_d    = ov_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    flip_d  = flip_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    armed_d = (start && arm_hit) ? 1'b0 : (armed_q || inj_trigger);
    if (start) begin
      mode_d = mode;
      epos_d = err_pos;
      mask_d = err_mask;
      shot_d = arm_hit;
    end
    if (accept) begin
      pos_d  = (p == P_LAST) ? P_FIRST : p - POS_W'(1);
      dout_d = d_in ^ flip;
      flip_d = flip;
      sof_d  = (p == P_FIRST);
      eof_d  = (p == P_LAST);
      ov_d   = 1'b1;
      if (p == P_LAST) begin
        fcnt_d = fcnt_q + CNT_W'(1);
      end
      if (flip && (ecnt_q != '1)) begin
        ecnt_d = ecnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= P_FIRST;
      armed_q <= 1'b0;
      mode_q  <= M_PASS;
      epos_q  <= '0;
      mask_q  <= '0;
      shot_q  <= 1'b0;
      dout_q  <= 1'b0;
      ov_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      flip_q  <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      pos_q   <= pos_d;
      armed_q <= armed_d;
      mode_q  <= mode_d;
      epos_q  <= epos_d;
      mask_q  <= mask_d;
      shot_q  <= shot_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      flip_q  <= flip_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign d_out     = dout_q;
  assign out_valid = ov_q;
  assign sof_out   = sof_q;
  assign eof_out   = eof_q;
  assign flipped   = flip_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_error_inject_frame.sv
// Bench for error_inject_frame: directed plan plus random traffic
// against a frame-level reference model.
module tb_error_inject_frame;

  localparam int FL = 7;
  localparam int PW = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, d_in, in_valid, in_ready, sof_in;
  logic [1:0]    mode;
  logic [PW-1:0] err_pos;
  logic [FL-1:0] err_mask;
  logic          inj_trigger;
  logic          d_out, out_valid, out_ready;
  logic          sof_out, eof_out, flipped;
  logic [CW-1:0] frame_cnt, err_cnt;

  error_inject_frame #(.FRAME_LEN(FL), .POS_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready), .sof_in(sof_in), .mode(mode),
    .err_pos(err_pos), .err_mask(err_mask),
    .inj_trigger(inj_trigger), .d_out(d_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .sof_out(sof_out), .eof_out(eof_out), .flipped(flipped),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  // reference model: bit index within frame counted from the first bit
  int            m_idx;
  int            m_mode;
  int            m_epos;
  logic [FL-1:0] m_mask;
  bit            m_shot, m_armed;
  bit            m_ov, m_d, m_f, m_s, m_e;
  int            m_fc, m_ec;

  logic [31:0] cap_d, cap_s, cap_e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_mode = 0; m_epos = 0; m_mask = '0;
    m_shot = 0; m_armed = 0;
    m_ov = 0; m_d = 0; m_f = 0; m_s = 0; m_e = 0;
    m_fc = 0; m_ec = 0;
    cap_d = '0; cap_s = '0; cap_e = '0;
  endtask

  task automatic model_accept(input bit d, input bit sof);
    int p;
    bit fl;
    if (sof) m_idx = 0;
    p = FL - 1 - m_idx;
    if (m_idx == 0) begin
      m_mode = int'(mode);
      m_epos = int'(err_pos);
      m_mask = err_mask;
      m_shot = (mode == 2'd3) && (m_armed || inj_trigger);
    end
    case (m_mode)
      0: fl = 0;
      1: fl = (p == m_epos);
      2: fl = m_mask[p];
      default: fl = m_shot && (p == m_epos);
    endcase
    m_ov = 1; m_d = d ^ fl; m_f = fl;
    m_s = (m_idx == 0); m_e = (p == 0);
    m_idx = (m_idx + 1) % FL;
    if (p == 0) m_fc = (m_fc + 1) % (1 << CW);
    if (fl && m_ec < (1 << CW) - 1) m_ec++;
  endtask

  task automatic step(input bit vld, input bit d, input bit sof,
                      input bit rdy, output bit acc);
    bit consume;
    in_valid = vld; d_in = d; sof_in = sof; out_ready = rdy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_ov || rdy));
    acc = vld && (!m_ov || rdy);
    if (m_ov && rdy) begin
      cap_d = {cap_d[30:0], d_out};
      cap_s = {cap_s[30:0], sof_out};
      cap_e = {cap_e[30:0], eof_out};
    end
    consume = acc && (sof || m_idx == 0) && (mode == 2'd3)
              && (m_armed || inj_trigger);
    if (acc) model_accept(d, sof);
    else if (rdy) m_ov = 0;
    m_armed = consume ? 1'b0 : (m_armed || inj_trigger);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("d_out", 32'(d_out), 32'(m_d));
      chk("flipped", 32'(flipped), 32'(m_f));
      chk("sof_out", 32'(sof_out), 32'(m_s));
      chk("eof_out", 32'(eof_out), 32'(m_e));
    end
    chk("frame_cnt", 32'(frame_cnt), m_fc);
    chk("err_cnt", 32'(err_cnt), m_ec);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; sof_in = 0; inj_trigger = 0;
    out_ready = 0; d_in = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_d", 32'(d_out), 0);
    chk("rst_flip", 32'(flipped), 0);
    chk("rst_sof", 32'(sof_out), 0);
    chk("rst_eof", 32'(eof_out), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    chk("rst_ecnt", 32'(err_cnt), 0);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    bit a;
    for (int i = 0; i < n; i++) begin
      step(1, bits[n-1-i], 0, 1, a);
      chk("send_acc", 32'(a), 1);
    end
    step(0, 0, 0, 1, a);
  endtask

  initial begin
    bit a;
    int i, c;
    logic [31:0] bp_bits;
    rst = 1; d_in = 0; in_valid = 0; sof_in = 0; mode = 0;
    err_pos = 0; err_mask = 0; inj_trigger = 0; out_ready = 0;

    // fixed position 6 on 1011010
    do_reset();
    mode = 2'b01; err_pos = 3'd6;
    send(32'b1011010, 7);
    chk("fix_data", {25'd0, cap_d[6:0]}, 32'b0011010);
    chk("fix_sof", {25'd0, cap_s[6:0]}, 32'b1000000);
    chk("fix_eof", {25'd0, cap_e[6:0]}, 32'b0000001);
    chk("fix_fcnt", 32'(frame_cnt), 1);
    chk("fix_ecnt", 32'(err_cnt), 1);

    // mask 1000001 on two zero frames
    do_reset();
    mode = 2'b10; err_mask = 7'b1000001;
    send(32'd0, 14);
    chk("mask_data", {18'd0, cap_d[13:0]}, 32'b10000011000001);
    chk("mask_ecnt", 32'(err_cnt), 4);
    chk("mask_fcnt", 32'(frame_cnt), 2);

    // backpressure: three stall cycles mid-frame
    do_reset();
    mode = 2'b01; err_pos = 3'd3;
    bp_bits = 32'b1100101;
    i = 0; c = 0;
    while (i < 7 && c < 50) begin
      out_ready = !(c >= 3 && c < 6);
      step(1, bp_bits[6-i], 0, !(c >= 3 && c < 6), a);
      if (a) i++;
      if (c >= 3 && c < 6) chk("stall_rdy", 32'(in_ready), 0);
      c++;
    end
    chk("bp_done", 32'(i), 7);
    step(0, 0, 0, 1, a);
    chk("bp_data", {25'd0, cap_d[6:0]}, 32'b1101101);

    // triggered one-shot armed mid-frame A, fires in frame B
    do_reset();
    mode = 2'b11; err_pos = 3'd2;
    for (int k = 0; k < 21; k++) begin
      inj_trigger = (k == 3);
      step(1, 0, 0, 1, a);
    end
    inj_trigger = 0;
    step(0, 0, 0, 1, a);
    chk("shot_data", {11'd0, cap_d[20:0]},
        32'b000000000001000000000);
    chk("shot_ecnt", 32'(err_cnt), 1);

    // mode change mid-frame has no effect until next frame
    do_reset();
    mode = 2'b01; err_pos = 3'd0;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) mode = 2'b00;
      step(1, 0, 0, 1, a);
    end
    step(0, 0, 0, 1, a);
    chk("cfg_data", {18'd0, cap_d[13:0]}, 32'b00000010000000);

    // sof realign then reset mid-frame
    do_reset();
    mode = 2'b00;
    for (int k = 0; k < 6; k++) step(1, 1, k == 3, 1, a);
    chk("sof_vec", {27'd0, cap_s[4:0]}, 32'b10010);
    chk("sof_fcnt", 32'(frame_cnt), 0);
    do_reset();
    send(32'b1010101, 7);
    chk("post_sof", {25'd0, cap_s[6:0]}, 32'b1000000);
    chk("post_fcnt", 32'(frame_cnt), 1);

    // random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      err_pos = 3'($urandom_range(0, 7));
      err_mask = 7'($urandom);
      inj_trigger = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, a);
    end
    inj_trigger = 0;

    // error counter saturation
    do_reset();
    mode = 2'b10; err_mask = '1;
    for (int k = 0; k < 65540; k++) step(1, 1'($urandom), 0, 1, a);
    chk("sat_ecnt", 32'(err_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
